// File: rtl/pwm_bank_if.sv
// pwm_bank_if: write-word bus from the SPI receiver into pwm_bank
interface pwm_bank_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 8
);
    logic [ADDR_W+WIDTH-1:0] wr_data;
    logic                    wr_valid;
    logic                    wr_err;
    modport master (output wr_data, wr_valid, input wr_err);
    modport slave (input wr_data, wr_valid, output wr_err);
endinterface

// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel PWM from one shared period counter with double-buffered duties
// Define PWM_RAMP_EN to slew each active duty one LSB per period toward its pending value.
module pwm_bank #(
    parameter int CHANNELS = 10,
    parameter int WIDTH    = 8,
    parameter int ADDR_W   = 8,
    parameter int PRESCALE = 1
) (
    input  logic                clk25M,
    input  logic                rst_n,
    pwm_bank_if.slave           wr,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'((1 << WIDTH) - 2);

    logic [PW-1:0]     pcnt;
    logic [WIDTH-1:0]  cnt;
    logic [WIDTH-1:0]  pending   [CHANNELS];
    logic [WIDTH-1:0]  active    [CHANNELS];
    logic [WIDTH-1:0]  active_nx [CHANNELS];
    logic              wv_q, tick, boundary, wr_hit, bcast, addr_ok;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  duty;

    assign tick     = pcnt == PW'(PRESCALE - 1);
    assign boundary = tick && cnt == CNT_LAST;
    assign wr_hit   = wr.wr_valid && !wv_q;
    assign addr     = wr.wr_data[ADDR_W+WIDTH-1:WIDTH];
    assign duty     = wr.wr_data[WIDTH-1:0];
    assign bcast    = &addr;
    assign addr_ok  = bcast || (addr != '0 && 32'(addr) <= CHANNELS);

    always_comb
        for (int i = 0; i < CHANNELS; i++)
`ifdef PWM_RAMP_EN
            active_nx[i] = pending[i] > active[i] ? active[i] + 1'b1 :
                           pending[i] < active[i] ? active[i] - 1'b1 : active[i];
`else
            active_nx[i] = pending[i];
`endif

    // wv_q resets high so a strobe held through reset release is not taken as a write
    always_ff @(posedge clk25M or negedge rst_n) begin
        if (!rst_n) begin
            pcnt         <= '0;
            cnt          <= '0;
            wv_q         <= 1'b1;
            pwm_out      <= '0;
            period_start <= 1'b0;
            wr.wr_err    <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                pending[i] <= '0;
                active[i]  <= '0;
            end
        end else begin
            pcnt         <= tick ? '0 : pcnt + 1'b1;
            if (tick)
                cnt <= boundary ? '0 : cnt + 1'b1;
            wv_q         <= wr.wr_valid;
            period_start <= boundary;
            wr.wr_err    <= wr_hit && !addr_ok;
            for (int i = 0; i < CHANNELS; i++) begin
                pwm_out[i] <= active[i] > cnt;
                if (boundary)
                    active[i] <= active_nx[i];
                if (wr_hit && (bcast || 32'(addr) == i + 1))
                    pending[i] <= duty;
            end
        end
    end
endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: scoreboard bench for pwm_bank (4 channels, 4-bit duty), plus a PRESCALE=3 instance
module tb_pwm_bank;
    typedef struct packed {
        int          end_cyc;
        logic [15:0] duties;
    } per_t;

    logic       clk25M = 1'b0;
    logic       rst_n, rst3_n;
    logic [3:0] pwm_out, pwm3;
    logic       period_start, ps3;
    int         total = 0, bad = 0, cyc = 0, idx = 0;
    bit         mon_en = 1'b1, prev_wv = 1'b1;
    per_t       per_q [$];
    int         err_q [$];
    logic [3:0] pend [4], act [4];
    logic [14:0] pat [4];

    pwm_bank_if #(.WIDTH(4), .ADDR_W(8)) bus ();
    pwm_bank_if #(.WIDTH(4), .ADDR_W(8)) bus3 ();

    pwm_bank #(.CHANNELS(4), .WIDTH(4), .ADDR_W(8), .PRESCALE(1)) dut (
        .clk25M(clk25M), .rst_n(rst_n), .wr(bus), .pwm_out(pwm_out), .period_start(period_start));
    pwm_bank #(.CHANNELS(4), .WIDTH(4), .ADDR_W(8), .PRESCALE(3)) dut3 (
        .clk25M(clk25M), .rst_n(rst3_n), .wr(bus3), .pwm_out(pwm3), .period_start(ps3));

    always #20 clk25M = ~clk25M;

    initial forever begin
        @(posedge clk25M);
        if (rst_n) cyc++;
    end

    task automatic check(string name, int got, int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // One clock of stimulus; the expected effect of the coming edge is queued before it happens
    task automatic step();
        logic [7:0]  a;
        logic [3:0]  d;
        logic [15:0] pk;
        bit          det;
        det     = bus.wr_valid && !prev_wv;
        prev_wv = bus.wr_valid;
        a       = bus.wr_data[11:4];
        d       = bus.wr_data[3:0];
        pk      = '0;
        if ((cyc + 1) % 15 == 0) begin
            for (int c = 0; c < 4; c++) begin
`ifdef PWM_RAMP_EN
                act[c] = pend[c] > act[c] ? act[c] + 4'd1 : pend[c] < act[c] ? act[c] - 4'd1 : act[c];
`else
                act[c] = pend[c];
`endif
                pk[c*4 +: 4] = act[c];
            end
            per_q.push_back('{cyc + 16, pk});
        end
        if (det) begin
            if (a == 8'hFF)
                for (int c = 0; c < 4; c++) pend[c] = d;
            else if (a >= 8'd1 && a <= 8'd4)
                pend[int'(a) - 1] = d;
            else
                err_q.push_back(cyc + 1);
        end
        @(negedge clk25M);
    endtask

    task automatic idle(int n);
        repeat (n) step();
    endtask

    task automatic wr(logic [7:0] a, logic [3:0] d);
        bus.wr_data  = {a, d};
        bus.wr_valid = 1'b1;
        step();
        bus.wr_valid = 1'b0;
        step();
    endtask

    task automatic measure3(int ch, output int n, output int hi);
        n  = 0;
        hi = 0;
        do begin
            @(negedge clk25M);
            n++;
            hi += int'(pwm3[ch]);
        end while (!ps3 && n < 200);
    endtask

    // Monitor: each period window of 15 samples is compared with the queued duties
    initial forever begin
        per_t        e;
        logic [15:0] m;
        @(negedge clk25M);
        if (!rst_n) begin
            idx = 0;
            for (int c = 0; c < 4; c++) pat[c] = '0;
        end else if (mon_en) begin
            for (int c = 0; c < 4; c++)
                if (idx < 15) pat[c][idx] = pwm_out[c];
            idx++;
            if (period_start) begin
                if (per_q.size() == 0)
                    check("period_start_unexpected", cyc, -1);
                else begin
                    e = per_q.pop_front();
                    check("period_cycle", cyc, e.end_cyc);
                    for (int c = 0; c < 4; c++) begin
                        m = (16'd1 << e.duties[c*4 +: 4]) - 16'd1;
                        check($sformatf("ch%0d_pattern@%0d", c, cyc), int'(pat[c]), int'(m[14:0]));
                    end
                end
                idx = 0;
                for (int c = 0; c < 4; c++) pat[c] = '0;
            end
            if (bus.wr_err) begin
                if (err_q.size() == 0)
                    check("wr_err_unexpected", cyc, -1);
                else
                    check("wr_err_cycle", cyc, err_q.pop_front());
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, hi;
        rst_n         = 1'b0;
        rst3_n        = 1'b0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus3.wr_valid = 1'b0;
        bus3.wr_data  = '0;
        for (int c = 0; c < 4; c++) begin
            pend[c] = '0;
            act[c]  = '0;
        end
        repeat (3) @(negedge clk25M);
        check("rst_pwm_out", int'(pwm_out), 0);
        check("rst_period_start", int'(period_start), 0);
        check("rst_wr_err", int'(bus.wr_err), 0);
        rst_n   = 1'b1;
        prev_wv = 1'b1;
        per_q.push_back('{15, 16'h0});
        idle(3);
        wr(8'd1, 4'd5);
        idle(40);
        wr(8'd2, 4'd0);
        wr(8'd3, 4'd15);
        idle(50);
        wr(8'hFF, 4'd8);
        wr(8'd0, 4'd3);
        wr(8'd5, 4'd9);
        idle(40);
        while ((cyc + 1) % 15 != 0) step();
        wr(8'd2, 4'd11);
        idle(35);
        bus.wr_data  = {8'd4, 4'd3};
        bus.wr_valid = 1'b1;
        step();
        bus.wr_data  = {8'd4, 4'd12};
        idle(19);
        bus.wr_valid = 1'b0;
        idle(35);
        wr(8'd1, 4'd0);
        idle(130);
        wr(8'd1, 4'd6);
        idle(120);
        wr(8'd1, 4'd2);
        idle(90);
        while ((cyc + 1) % 15 != 5) step();
        check("err_queue_left", err_q.size(), 0);
        check("period_queue_depth", per_q.size(), 1);
        mon_en = 1'b0;

        rst3_n        = 1'b1;
        bus3.wr_data  = {8'd1, 4'd5};
        @(negedge clk25M);
        bus3.wr_valid = 1'b1;
        @(negedge clk25M);
        bus3.wr_valid = 1'b0;
        measure3(0, n, hi);
        check("p3_first_boundary", int'(ps3), 1);
        measure3(0, n, hi);
        check("p3_spacing", n, 45);
        check("p3_ch0_high", hi, 15);
        measure3(0, n, hi);
        check("p3_spacing2", n, 45);
        check("p3_ch0_high2", hi, 15);
        repeat (10) @(negedge clk25M);
        #5 rst3_n = 1'b0;
        #1;
        check("p3_async_rst_pwm", int'(pwm3), 0);
        check("p3_async_rst_ps", int'(ps3), 0);
        check("p3_async_rst_err", int'(bus3.wr_err), 0);
        bus3.wr_data  = {8'd2, 4'd9};
        bus3.wr_valid = 1'b1;
        repeat (2) @(negedge clk25M);
        rst3_n = 1'b1;
        hi = 0;
        n  = 0;
        repeat (100) begin
            @(negedge clk25M);
            hi += $countones(pwm3);
            n  += int'(bus3.wr_err);
        end
        check("p3_held_valid_no_write", hi, 0);
        check("p3_held_valid_no_err", n, 0);
        bus3.wr_valid = 1'b0;
        @(negedge clk25M);
        bus3.wr_valid = 1'b1;
        @(negedge clk25M);
        bus3.wr_valid = 1'b0;
        measure3(1, n, hi);
        measure3(1, n, hi);
        check("p3_spacing3", n, 45);
        check("p3_ch1_high", hi, 27);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
